// File: rtl/bias_scale_ctrl_if.sv
// Config-stream handshake carrying bias/scale words from the parameter loader
// into bias_scale_ctrl.
interface bias_scale_ctrl_if #(
  parameter int PARAM_W = 32
);
  logic               cfg_valid_i;
  logic               cfg_ready_o;
  logic [PARAM_W-1:0] cfg_data_i;
  logic               cfg_abort_i;

  modport master (
    output cfg_valid_i,
    output cfg_data_i,
    output cfg_abort_i,
    input  cfg_ready_o
  );

  modport slave (
    input  cfg_valid_i,
    input  cfg_data_i,
    input  cfg_abort_i,
    output cfg_ready_o
  );
endinterface

// File: rtl/bias_scale_ctrl.sv
// Double-buffered bias/scale parameter store: streams a full set into the shadow
// bank, then swaps banks atomically once the bias/scale pipeline drains.
module bias_scale_ctrl #(
  parameter int N       = 8,
  parameter int PARAM_W = 32,
  parameter int IDX_W   = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  bias_scale_ctrl_if.slave   cfg,
  input  logic               busy_i,
  input  logic [IDX_W-1:0]   rd_idx_i   [2],
  output logic [PARAM_W-1:0] rd_bias_o  [2],
  output logic [PARAM_W-1:0] rd_scale_o [2],
  output logic               params_valid_o,
  output logic               load_done_o,
  output logic               pending_o
);

  localparam logic [1:0] S_LOAD_BIAS  = 2'd0;
  localparam logic [1:0] S_LOAD_SCALE = 2'd1;
  localparam logic [1:0] S_PENDING    = 2'd2;

  localparam int                CNT_W     = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N - 1);
  localparam logic [IDX_W:0]    IDX_LIMIT = (IDX_W + 1)'(N);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               active_sel_q, active_sel_d;
  logic               params_valid_q, params_valid_d;
  logic               load_done_q, load_done_d;
  logic [PARAM_W-1:0] bias_q  [2][N];
  logic [PARAM_W-1:0] bias_d  [2][N];
  logic [PARAM_W-1:0] scale_q [2][N];
  logic [PARAM_W-1:0] scale_d [2][N];

  logic shadow_s;
  logic ready_s;
  logic accept_s;
  logic cnt_last_s;

  assign shadow_s       = ~active_sel_q;
  // Ready is forced low during reset so no beat is ever taken while rst is high.
  assign ready_s        = ((state_q == S_LOAD_BIAS) || (state_q == S_LOAD_SCALE)) & ~rst;
  assign cfg.cfg_ready_o = ready_s;
  assign accept_s       = cfg.cfg_valid_i & ready_s & ~cfg.cfg_abort_i;
  assign cnt_last_s     = (cnt_q == CNT_LAST);

  assign params_valid_o = params_valid_q;
  assign load_done_o    = load_done_q;
  assign pending_o      = (state_q == S_PENDING);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    active_sel_d   = active_sel_q;
    params_valid_d = params_valid_q;
    load_done_d    = 1'b0;
    bias_d         = bias_q;
    scale_d        = scale_q;

    // Abort outranks any beat or swap in the same cycle; the active bank is never touched.
    if (cfg.cfg_abort_i) begin
      state_d = S_LOAD_BIAS;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_LOAD_BIAS: begin
          if (accept_s) begin
            bias_d[shadow_s][cnt_q] = cfg.cfg_data_i;
            if (cnt_last_s) begin
              state_d = S_LOAD_SCALE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_LOAD_SCALE: begin
          if (accept_s) begin
            scale_d[shadow_s][cnt_q] = cfg.cfg_data_i;
            if (cnt_last_s) begin
              state_d = S_PENDING;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_PENDING: begin
          if (!busy_i) begin
            active_sel_d   = ~active_sel_q;
            load_done_d    = 1'b1;
            params_valid_d = 1'b1;
            state_d        = S_LOAD_BIAS;
            cnt_d          = '0;
          end else begin
            state_d = S_PENDING;
          end
        end
        default: begin
          state_d = S_LOAD_BIAS;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_LOAD_BIAS;
      cnt_q          <= '0;
      active_sel_q   <= 1'b0;
      params_valid_q <= 1'b0;
      load_done_q    <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          bias_q[b][i]  <= '0;
          scale_q[b][i] <= '0;
        end
      end
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      active_sel_q   <= active_sel_d;
      params_valid_q <= params_valid_d;
      load_done_q    <= load_done_d;
      bias_q         <= bias_d;
      scale_q        <= scale_d;
    end
  end

  // Out-of-range indices read as zero rather than aliasing into the bank.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      if ({1'b0, rd_idx_i[k]} < IDX_LIMIT) begin
        rd_bias_o[k]  = bias_q[active_sel_q][rd_idx_i[k]];
        rd_scale_o[k] = scale_q[active_sel_q][rd_idx_i[k]];
      end else begin
        rd_bias_o[k]  = '0;
        rd_scale_o[k] = '0;
      end
    end
  end

endmodule

// File: tb/tb_bias_scale_ctrl.sv
// Directed, table-driven bench for bias_scale_ctrl (N=8), plus a small N=9
// instance for the out-of-range read index.
module tb_bias_scale_ctrl;

  localparam int N  = 8;
  localparam int PW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          busy;
  logic [2:0]    rd_idx   [2];
  logic [PW-1:0] rd_bias  [2];
  logic [PW-1:0] rd_scale [2];
  logic          params_valid, load_done, pending;

  logic [3:0]    rd_idx9   [2];
  logic [PW-1:0] rd_bias9  [2];
  logic [PW-1:0] rd_scale9 [2];
  logic          params_valid9, load_done9, pending9;

  bias_scale_ctrl_if #(.PARAM_W(PW)) cfg_if ();
  bias_scale_ctrl_if #(.PARAM_W(PW)) cfg9_if ();

  bias_scale_ctrl #(.N(N), .PARAM_W(PW)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg            (cfg_if),
    .busy_i         (busy),
    .rd_idx_i       (rd_idx),
    .rd_bias_o      (rd_bias),
    .rd_scale_o     (rd_scale),
    .params_valid_o (params_valid),
    .load_done_o    (load_done),
    .pending_o      (pending)
  );

  bias_scale_ctrl #(.N(9), .PARAM_W(PW)) dut9 (
    .clk            (clk),
    .rst            (rst),
    .cfg            (cfg9_if),
    .busy_i         (busy),
    .rd_idx_i       (rd_idx9),
    .rd_bias_o      (rd_bias9),
    .rd_scale_o     (rd_scale9),
    .params_valid_o (params_valid9),
    .load_done_o    (load_done9),
    .pending_o      (pending9)
  );

  typedef struct {
    int bias_base;
    int scale_base;
    int gap;
    int busy_cyc;
    int abort_beat;
    int idx0;
    int idx1;
    int old_b0;
    int exp_b0;
    int exp_b1;
    int exp_s0;
    int exp_s1;
  } vec_t;

  vec_t tbl [5];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input vec_t v);
    int beat;
    int cyc_n;
    rd_idx[0] = 3'(v.idx0);
    rd_idx[1] = 3'(v.idx1);
    busy = 1'b0;
    if (v.abort_beat >= 0) begin
      for (int b = 0; b < v.abort_beat; b++) begin
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_data_i  = 32'(800 + b);
        cyc();
      end
      cfg_if.cfg_abort_i = 1'b1;
      cfg_if.cfg_data_i  = 32'(800 + v.abort_beat);
      #1;
      chk1("abort_no_done", load_done, 1'b0);
      cyc();
      cfg_if.cfg_abort_i = 1'b0;
      cfg_if.cfg_valid_i = 1'b0;
      #1;
      chk1("abort_ready", cfg_if.cfg_ready_o, 1'b1);
      chk("abort_keep_rd", rd_bias[0], v.old_b0);
      cyc();
    end

    beat  = 0;
    cyc_n = 0;
    while (beat < 2 * N && cyc_n < 100) begin
      cfg_if.cfg_valid_i = (v.gap != 0 && (cyc_n % 2) == 1) ? 1'b0 : 1'b1;
      cfg_if.cfg_data_i  = (beat < N) ? 32'(v.bias_base + beat) : 32'(v.scale_base + beat - N);
      #1;
      chk1("load_ready", cfg_if.cfg_ready_o, 1'b1);
      chk1("load_no_done", load_done, 1'b0);
      chk("load_hold_rd", rd_bias[0], v.old_b0);
      if (cfg_if.cfg_valid_i) beat++;
      cyc();
      cyc_n++;
    end
    cfg_if.cfg_valid_i = 1'b0;

    for (int i = 0; i < v.busy_cyc; i++) begin
      busy = 1'b1;
      #1;
      chk1("busy_pending", pending, 1'b1);
      chk1("busy_ready", cfg_if.cfg_ready_o, 1'b0);
      chk("busy_hold_rd", rd_bias[0], v.old_b0);
      cyc();
    end
    busy = 1'b0;
    #1;
    chk1("pend_ready", cfg_if.cfg_ready_o, 1'b0);
    chk1("pend_flag", pending, 1'b1);
    chk("pend_hold_rd", rd_bias[0], v.old_b0);
    cyc();

    #1;
    chk1("swap_done", load_done, 1'b1);
    chk1("swap_pvalid", params_valid, 1'b1);
    chk1("swap_ready", cfg_if.cfg_ready_o, 1'b1);
    chk1("swap_pending", pending, 1'b0);
    chk("swap_bias0", rd_bias[0], v.exp_b0);
    chk("swap_bias1", rd_bias[1], v.exp_b1);
    chk("swap_scale0", rd_scale[0], v.exp_s0);
    chk("swap_scale1", rd_scale[1], v.exp_s1);
    cyc();
    #1;
    chk1("done_pulse_end", load_done, 1'b0);

    for (int i = 0; i < N; i++) begin
      rd_idx[0] = 3'(i);
      rd_idx[1] = 3'(N - 1 - i);
      #1;
      chk("rb_bias", rd_bias[0], v.bias_base + i);
      chk("rb_scale", rd_scale[1], v.scale_base + N - 1 - i);
      cyc();
    end
  endtask

  initial begin
    //        bias  scale gap busy abort idx0 idx1 old   exp_b0 exp_b1 exp_s0 exp_s1
    tbl[0] = '{100,  200,  0,  0,  -1,   2,   5,   0,    102,   105,   202,   205};
    tbl[1] = '{300,  400,  0,  5,  -1,   0,   7,   100,  300,   307,   400,   407};
    tbl[2] = '{600,  700,  1,  0,  -1,   7,   3,   307,  607,   603,   707,   703};
    tbl[3] = '{500,  550,  0,  0,   5,   1,   6,   601,  501,   506,   551,   556};
    tbl[4] = '{1000, 1100, 0,  0,  -1,   4,   0,   504,  1004,  1000,  1104,  1100};

    rst = 1'b1;
    busy = 1'b0;
    cfg_if.cfg_valid_i  = 1'b0;
    cfg_if.cfg_data_i   = '0;
    cfg_if.cfg_abort_i  = 1'b0;
    cfg9_if.cfg_valid_i = 1'b0;
    cfg9_if.cfg_data_i  = '0;
    cfg9_if.cfg_abort_i = 1'b0;
    rd_idx[0]  = 3'd3;
    rd_idx[1]  = 3'd7;
    rd_idx9[0] = 4'd0;
    rd_idx9[1] = 4'd0;
    cyc();
    cyc();
    chk1("rst_ready_low", cfg_if.cfg_ready_o, 1'b0);
    rst = 1'b0;
    #1;
    chk1("post_rst_ready", cfg_if.cfg_ready_o, 1'b1);
    chk1("post_rst_pvalid", params_valid, 1'b0);
    chk1("post_rst_pending", pending, 1'b0);
    chk1("post_rst_done", load_done, 1'b0);
    chk("post_rst_bias0", rd_bias[0], 0);
    chk("post_rst_bias1", rd_bias[1], 0);
    chk("post_rst_scale0", rd_scale[0], 0);
    chk("post_rst_scale1", rd_scale[1], 0);
    cyc();

    for (int t = 0; t < 4; t++) run_load(tbl[t]);

    // Abort arriving in PENDING together with an idle pipeline must not swap.
    rd_idx[0] = 3'd4;
    rd_idx[1] = 3'd4;
    for (int b = 0; b < 2 * N; b++) begin
      cfg_if.cfg_valid_i = 1'b1;
      cfg_if.cfg_data_i  = 32'(900 + b);
      cyc();
    end
    cfg_if.cfg_valid_i = 1'b0;
    cfg_if.cfg_abort_i = 1'b1;
    busy = 1'b0;
    #1;
    chk1("pabort_pending", pending, 1'b1);
    chk1("pabort_ready", cfg_if.cfg_ready_o, 1'b0);
    cyc();
    cfg_if.cfg_abort_i = 1'b0;
    #1;
    chk1("pabort_ready_next", cfg_if.cfg_ready_o, 1'b1);
    chk1("pabort_no_pending", pending, 1'b0);
    chk1("pabort_no_done", load_done, 1'b0);
    chk("pabort_bias", rd_bias[0], 504);
    chk("pabort_scale", rd_scale[1], 554);
    cyc();
    #1;
    chk1("pabort_no_done2", load_done, 1'b0);
    chk("pabort_bias2", rd_bias[0], 504);
    cyc();

    run_load(tbl[4]);

    // Reset in the middle of a load drops everything back to the reset state.
    for (int b = 0; b < 3; b++) begin
      cfg_if.cfg_valid_i = 1'b1;
      cfg_if.cfg_data_i  = 32'(1200 + b);
      cyc();
    end
    rst = 1'b1;
    cyc();
    chk1("mrst_pvalid", params_valid, 1'b0);
    chk1("mrst_ready", cfg_if.cfg_ready_o, 1'b0);
    chk("mrst_bias", rd_bias[0], 0);
    rst = 1'b0;
    cfg_if.cfg_valid_i = 1'b0;
    #1;
    chk1("mrst_ready_after", cfg_if.cfg_ready_o, 1'b1);
    chk1("mrst_pending", pending, 1'b0);
    cyc();

    for (int b = 0; b < 18; b++) begin
      cfg9_if.cfg_valid_i = 1'b1;
      cfg9_if.cfg_data_i  = (b < 9) ? 32'(10 + b) : 32'(20 + b - 9);
      cyc();
    end
    cfg9_if.cfg_valid_i = 1'b0;
    cyc();
    rd_idx9[0] = 4'd8;
    rd_idx9[1] = 4'd9;
    #1;
    chk1("n9_done", load_done9, 1'b1);
    chk1("n9_pvalid", params_valid9, 1'b1);
    chk("n9_bias_last", rd_bias9[0], 18);
    chk("n9_bias_oor", rd_bias9[1], 0);
    chk("n9_scale_last", rd_scale9[0], 28);
    chk("n9_scale_oor", rd_scale9[1], 0);
    rd_idx9[0] = 4'd15;
    rd_idx9[1] = 4'd0;
    #1;
    chk("n9_bias_oor15", rd_bias9[0], 0);
    chk("n9_bias_first", rd_bias9[1], 10);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
